axi_write_arbiter: RTL and testbench

- Two-master round-robin arbiter sharing one AXI3-style write slave (the team's write slave + memory path) across the AW, W and B channels.
- Grants one complete write transaction at a time: address, then all data beats, then the response.
- Steers each channel between the granted master and the slave, and routes the response back to the granted master only.
- Checks burst length against WLAST and forces a correct WLAST to the slave.

---
 rtl/axi_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Two-master round-robin arbiter for one AXI3-style write slave.
// One whole write (AW, all W beats, B) is owned by a single master at a time.
// The slave always sees a WLAST derived from AWLEN, not the master's own WLAST.
module axi_write_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // Master 0
  input  logic [ID_W-1:0]     m0_AWID,
  input  logic [ADDR_W-1:0]   m0_AWADDR,
  input  logic [3:0]          m0_AWLEN,
  input  logic [2:0]          m0_AWSIZE,
  input  logic [1:0]          m0_AWBURST,
  input  logic [8:0]          m0_AWATTR,
  input  logic                m0_AWVALID,
  output logic                m0_AWREADY,
  input  logic [ID_W-1:0]     m0_WID,
  input  logic [DATA_W-1:0]   m0_WDATA,
  input  logic [DATA_W/8-1:0] m0_WSTRB,
  input  logic                m0_WLAST,
  input  logic                m0_WVALID,
  output logic                m0_WREADY,
  output logic [ID_W-1:0]     m0_BID,
  output logic [1:0]          m0_BRESP,
  output logic                m0_BVALID,
  input  logic                m0_BREADY,
  // Master 1
  input  logic [ID_W-1:0]     m1_AWID,
  input  logic [ADDR_W-1:0]   m1_AWADDR,
  input  logic [3:0]          m1_AWLEN,
  input  logic [2:0]          m1_AWSIZE,
  input  logic [1:0]          m1_AWBURST,
  input  logic [8:0]          m1_AWATTR,
  input  logic                m1_AWVALID,
  output logic                m1_AWREADY,
  input  logic [ID_W-1:0]     m1_WID,
  input  logic [DATA_W-1:0]   m1_WDATA,
  input  logic [DATA_W/8-1:0] m1_WSTRB,
  input  logic                m1_WLAST,
  input  logic                m1_WVALID,
  output logic                m1_WREADY,
  output logic [ID_W-1:0]     m1_BID,
  output logic [1:0]          m1_BRESP,
  output logic                m1_BVALID,
  input  logic                m1_BREADY,
  // Slave
  output logic [ID_W-1:0]     s_AWID,
  output logic [ADDR_W-1:0]   s_AWADDR,
  output logic [3:0]          s_AWLEN,
  output logic [2:0]          s_AWSIZE,
  output logic [1:0]          s_AWBURST,
  output logic [8:0]          s_AWATTR,
  output logic                s_AWVALID,
  input  logic                s_AWREADY,
  output logic [ID_W-1:0]     s_WID,
  output logic [DATA_W-1:0]   s_WDATA,
  output logic [DATA_W/8-1:0] s_WSTRB,
  output logic                s_WLAST,
  output logic                s_WVALID,
  input  logic                s_WREADY,
  input  logic [ID_W-1:0]     s_BID,
  input  logic [1:0]          s_BRESP,
  input  logic                s_BVALID,
  output logic                s_BREADY,
  // Status
  output logic                grant,
  output logic                busy,
  output logic                err_len
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e     state_q;
  logic       grant_q, busy_q, prio_q, err_len_q;
  logic [3:0] len_q, cnt_q;

  logic in_addr, in_data, in_resp;
  logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic [3:0] sel_awlen;
  logic aw_hs, w_hs, b_hs, last_beat;

  assign in_addr   = (state_q == StAddr);
  assign in_data   = (state_q == StData);
  assign in_resp   = (state_q == StResp);
  assign last_beat = (cnt_q == len_q);

  assign aw_hs = in_addr & sel_awvalid & s_AWREADY;
  assign w_hs  = in_data & sel_wvalid & s_WREADY;
  assign b_hs  = in_resp & s_BVALID & sel_bready;

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign err_len = err_len_q;

  // Control signals of the currently granted master.
  always_comb begin
    sel_awvalid = grant_q ? m1_AWVALID : m0_AWVALID;
    sel_awlen   = grant_q ? m1_AWLEN   : m0_AWLEN;
    sel_wvalid  = grant_q ? m1_WVALID  : m0_WVALID;
    sel_wlast   = grant_q ? m1_WLAST   : m0_WLAST;
    sel_bready  = grant_q ? m1_BREADY  : m0_BREADY;
  end

  // Channel steering; handshakes only open in their own phase and only for the owner.
  always_comb begin
    s_AWID     = grant_q ? m1_AWID    : m0_AWID;
    s_AWADDR   = grant_q ? m1_AWADDR  : m0_AWADDR;
    s_AWLEN    = sel_awlen;
    s_AWSIZE   = grant_q ? m1_AWSIZE  : m0_AWSIZE;
    s_AWBURST  = grant_q ? m1_AWBURST : m0_AWBURST;
    s_AWATTR   = grant_q ? m1_AWATTR  : m0_AWATTR;
    s_AWVALID  = in_addr & sel_awvalid;
    s_WID      = grant_q ? m1_WID     : m0_WID;
    s_WDATA    = grant_q ? m1_WDATA   : m0_WDATA;
    s_WSTRB    = grant_q ? m1_WSTRB   : m0_WSTRB;
    s_WLAST    = in_data & last_beat;
    s_WVALID   = in_data & sel_wvalid;
    s_BREADY   = in_resp & sel_bready;
    m0_AWREADY = in_addr & ~grant_q & s_AWREADY;
    m1_AWREADY = in_addr &  grant_q & s_AWREADY;
    m0_WREADY  = in_data & ~grant_q & s_WREADY;
    m1_WREADY  = in_data &  grant_q & s_WREADY;
    m0_BVALID  = in_resp & ~grant_q & s_BVALID;
    m1_BVALID  = in_resp &  grant_q & s_BVALID;
    m0_BID     = (in_resp & ~grant_q) ? s_BID   : '0;
    m0_BRESP   = (in_resp & ~grant_q) ? s_BRESP : '0;
    m1_BID     = (in_resp &  grant_q) ? s_BID   : '0;
    m1_BRESP   = (in_resp &  grant_q) ? s_BRESP : '0;
  end

  // Transaction FSM; err_len is registered, so it is high the cycle after the bad beat.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      prio_q    <= 1'b0;
      err_len_q <= 1'b0;
      len_q     <= 4'd0;
      cnt_q     <= 4'd0;
    end else begin
      err_len_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (m0_AWVALID || m1_AWVALID) begin
            grant_q <= (m0_AWVALID && m1_AWVALID) ? prio_q : m1_AWVALID;
            busy_q  <= 1'b1;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (aw_hs) begin
            len_q   <= sel_awlen;
            cnt_q   <= 4'd0;
            state_q <= StData;
          end
        end
        StData: begin
          if (w_hs) begin
            cnt_q     <= cnt_q + 4'd1;
            err_len_q <= (sel_wlast != last_beat);
            if (last_beat) state_q <= StResp;
          end
        end
        StResp: begin
          if (b_hs) begin
            prio_q  <= ~grant_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: a table of directed transactions,
// a reset-mid-burst sequence and random transactions against a transaction-level model.
module tb_axi_write_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [IW-1:0] m_awid   [2];
  logic [AW-1:0] m_awaddr [2];
  logic [3:0]    m_awlen  [2];
  logic [2:0]    m_awsize [2];
  logic [1:0]    m_awburst[2];
  logic [8:0]    m_awattr [2];
  logic [IW-1:0] m_wid    [2];
  logic [DW-1:0] m_wdata  [2];
  logic [SW-1:0] m_wstrb  [2];
  logic [DW-1:0] base     [2];
  logic [1:0]    m_awvalid, m_wvalid, m_wlast, m_bready;
  wire  [1:0]    m_awready, m_wready, m_bvalid;
  wire  [IW-1:0] m0_bid, m1_bid;
  wire  [1:0]    m0_bresp, m1_bresp;

  wire  [IW-1:0] s_awid;
  wire  [AW-1:0] s_awaddr;
  wire  [3:0]    s_awlen;
  wire  [2:0]    s_awsize;
  wire  [1:0]    s_awburst;
  wire  [8:0]    s_awattr;
  wire           s_awvalid;
  logic          s_awready;
  wire  [IW-1:0] s_wid;
  wire  [DW-1:0] s_wdata;
  wire  [SW-1:0] s_wstrb;
  wire           s_wlast, s_wvalid;
  logic          s_wready;
  logic [IW-1:0] s_bid;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  wire           s_bready;
  wire           grant, busy, err_len;

  axi_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_AWID(m_awid[0]), .m0_AWADDR(m_awaddr[0]), .m0_AWLEN(m_awlen[0]),
    .m0_AWSIZE(m_awsize[0]), .m0_AWBURST(m_awburst[0]), .m0_AWATTR(m_awattr[0]),
    .m0_AWVALID(m_awvalid[0]), .m0_AWREADY(m_awready[0]),
    .m0_WID(m_wid[0]), .m0_WDATA(m_wdata[0]), .m0_WSTRB(m_wstrb[0]),
    .m0_WLAST(m_wlast[0]), .m0_WVALID(m_wvalid[0]), .m0_WREADY(m_wready[0]),
    .m0_BID(m0_bid), .m0_BRESP(m0_bresp), .m0_BVALID(m_bvalid[0]), .m0_BREADY(m_bready[0]),
    .m1_AWID(m_awid[1]), .m1_AWADDR(m_awaddr[1]), .m1_AWLEN(m_awlen[1]),
    .m1_AWSIZE(m_awsize[1]), .m1_AWBURST(m_awburst[1]), .m1_AWATTR(m_awattr[1]),
    .m1_AWVALID(m_awvalid[1]), .m1_AWREADY(m_awready[1]),
    .m1_WID(m_wid[1]), .m1_WDATA(m_wdata[1]), .m1_WSTRB(m_wstrb[1]),
    .m1_WLAST(m_wlast[1]), .m1_WVALID(m_wvalid[1]), .m1_WREADY(m_wready[1]),
    .m1_BID(m1_bid), .m1_BRESP(m1_bresp), .m1_BVALID(m_bvalid[1]), .m1_BREADY(m_bready[1]),
    .s_AWID(s_awid), .s_AWADDR(s_awaddr), .s_AWLEN(s_awlen), .s_AWSIZE(s_awsize),
    .s_AWBURST(s_awburst), .s_AWATTR(s_awattr), .s_AWVALID(s_awvalid), .s_AWREADY(s_awready),
    .s_WID(s_wid), .s_WDATA(s_wdata), .s_WSTRB(s_wstrb), .s_WLAST(s_wlast),
    .s_WVALID(s_wvalid), .s_WREADY(s_wready),
    .s_BID(s_bid), .s_BRESP(s_bresp), .s_BVALID(s_bvalid), .s_BREADY(s_bready),
    .grant(grant), .busy(busy), .err_len(err_len)
  );

  int errors = 0;
  int checks = 0;
  int ptr    = 0;  // model round-robin pointer

  typedef struct packed {
    bit         r0;
    bit         r1;
    logic [3:0] len;
    logic [3:0] wl;     // beat index on which the master raises WLAST
    logic [1:0] bresp;
    bit         bp;     // WREADY toggling + 5-cycle B delay
    bit         g;      // expected grant
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid_ready"},
        64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_err_len"}, 64'(err_len), 64'd0);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // One complete transaction; abort_beat >= 0 asserts ARESET while that beat is offered.
  task automatic run_txn(input bit r0, input bit r1, input int len, input int wl,
                         input logic [1:0] bresp, input bit bp, input int exp_g,
                         input int abort_beat);
    int g, lo, b, cyc, bd;
    bit hs, mism, islast;
    g  = exp_g;
    lo = 1 - g;
    for (int m = 0; m < 2; m++) begin
      m_awid[m]    = IW'($urandom);
      m_awaddr[m]  = $urandom;
      m_awlen[m]   = (m == g) ? len[3:0] : 4'($urandom);
      m_awsize[m]  = 3'($urandom);
      m_awburst[m] = 2'($urandom);
      m_awattr[m]  = 9'($urandom);
      m_wid[m]     = m_awid[m];
      m_wstrb[m]   = SW'($urandom);
      base[m]      = $urandom;
      m_wdata[m]   = base[m];
    end
    m_awvalid = {r1, r0};
    m_wvalid  = '1;  // early W must be stalled until the AW handshake
    step();  // arbitration edge
    // Address phase
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 100) begin
      s_awready    = 1'($urandom_range(0, 1));
      m_awvalid[g] = (cyc != 1);  // dropping AWVALID must keep the grant
      @(negedge ACLK);
      chk("aw_busy", 64'(busy), 64'd1);
      chk("aw_grant", 64'(grant), 64'(g));
      chk("aw_w_stall", 64'({m_wready, s_wvalid}), 64'd0);
      chk("aw_loser_awready", 64'(m_awready[lo]), 64'd0);
      chk("s_awvalid", 64'(s_awvalid), 64'(m_awvalid[g]));
      chk("m_awready", 64'(m_awready[g]), 64'(s_awready));
      hs = m_awvalid[g] && s_awready;
      if (hs)
        chk("s_aw_payload", 64'({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awattr}),
            64'({m_awid[g], m_awaddr[g], m_awlen[g], m_awsize[g], m_awburst[g], m_awattr[g]}));
      step();
      chk("aw_err_len", 64'(err_len), 64'd0);
      cyc++;
    end
    if (!hs) chk("aw_timeout", 64'd1, 64'd0);
    m_awvalid[g] = 1'b0;
    // Data phase
    b = 0; cyc = 0; mism = 1'b0;
    while (hs && b <= len && cyc < 300) begin
      if (b == abort_beat) begin
        m_wvalid[g] = 1'b1; s_wready = 1'b1; ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        chk_quiet("reset_mid_burst");
        idle_inputs();
        ptr = 0;
        return;
      end
      m_wvalid[g]  = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
      m_wdata[g]   = base[g] + DW'(b);
      m_wlast[g]   = (b == wl);
      m_wvalid[lo] = 1'($urandom);
      m_wlast[lo]  = 1'($urandom);
      s_wready     = bp ? ~s_wready : 1'($urandom_range(0, 1));
      islast       = (b == len);
      @(negedge ACLK);
      chk("w_busy_grant", 64'({busy, grant}), 64'({1'b1, g[0]}));
      chk("s_wvalid", 64'(s_wvalid), 64'(m_wvalid[g]));
      chk("m_wready", 64'(m_wready[g]), 64'(s_wready));
      chk("w_loser_ready", 64'({m_wready[lo], m_awready[lo]}), 64'd0);
      hs = m_wvalid[g] && s_wready;
      if (hs) begin
        chk("s_w_payload", 64'({s_wid, s_wdata, s_wstrb}),
            64'({m_wid[g], m_wdata[g], m_wstrb[g]}));
        chk("s_wlast", 64'(s_wlast), 64'(islast));
      end
      mism = hs && (m_wlast[g] != islast);
      step();
      chk("err_len", 64'(err_len), 64'(mism));
      if (hs) b++;
      hs = 1'b1;
      cyc++;
    end
    if (b <= len) chk("w_timeout", 64'd1, 64'd0);
    // Response phase
    m_wvalid[g] = 1'b1;  // must not leak through while in the response phase
    m_wlast = '0;
    s_bid   = m_awid[g];
    s_bresp = bresp;
    bd = bp ? 5 : $urandom_range(0, 3);
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 100) begin
      s_bvalid     = (cyc >= bd);
      m_bready[g]  = bp ? 1'b1 : ($urandom_range(0, 3) != 0);
      m_bready[lo] = 1'($urandom);
      @(negedge ACLK);
      chk("b_busy_grant", 64'({busy, grant}), 64'({1'b1, g[0]}));
      chk("b_no_w", 64'({s_wvalid, m_wready}), 64'd0);
      chk("m_bvalid", 64'(m_bvalid[g]), 64'(s_bvalid));
      chk("s_bready", 64'(s_bready), 64'(m_bready[g]));
      chk("b_loser_bvalid", 64'(m_bvalid[lo]), 64'd0);
      chk("b_loser_bid", 64'(lo ? {m1_bid, m1_bresp} : {m0_bid, m0_bresp}), 64'd0);
      if (s_bvalid)
        chk("m_bid_bresp", 64'(g ? {m1_bid, m1_bresp} : {m0_bid, m0_bresp}),
            64'({m_awid[g], bresp}));
      hs = s_bvalid && m_bready[g];
      step();
      chk("b_err_len", 64'(err_len), 64'd0);
      cyc++;
    end
    if (!hs) chk("b_timeout", 64'd1, 64'd0);
    chk("idle_after_b", 64'(busy), 64'd0);
    ptr = 1 - g;
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, r1, len, wl, g;
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = '0; m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0;
      m_awburst[m] = '0; m_awattr[m] = '0; m_wid[m] = '0; m_wdata[m] = '0;
      m_wstrb[m] = '0; base[m] = '0;
    end
    idle_inputs();
    m_awvalid = 2'b11;  // requests during reset must be ignored
    ARESET = 1'b1;
    step();
    step();
    chk_quiet("reset");
    ARESET = 1'b0;
    m_awvalid = '0;
    step();
    chk_quiet("post_reset_idle");

    //            r0 r1 len    wl     bresp  bp g
    tbl[0] = '{1, 0, 4'd3,  4'd3,  2'b00, 0, 0};
    tbl[1] = '{1, 1, 4'd0,  4'd0,  2'b00, 0, 1};
    tbl[2] = '{1, 1, 4'd0,  4'd0,  2'b00, 0, 0};
    tbl[3] = '{1, 1, 4'd0,  4'd0,  2'b00, 0, 1};
    tbl[4] = '{1, 1, 4'd0,  4'd0,  2'b00, 0, 0};
    tbl[5] = '{1, 1, 4'd0,  4'd0,  2'b00, 0, 1};
    tbl[6] = '{0, 1, 4'd2,  4'd1,  2'b10, 0, 1};
    tbl[7] = '{1, 0, 4'd15, 4'd15, 2'b01, 1, 0};
    tbl[8] = '{1, 1, 4'd1,  4'd0,  2'b11, 1, 1};
    tbl[9] = '{1, 1, 4'd0,  4'd5,  2'b00, 0, 0};
    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].r0, tbl[i].r1, int'(tbl[i].len), int'(tbl[i].wl), tbl[i].bresp,
              tbl[i].bp, int'(tbl[i].g), -1);

    // Reset during beat 2 of a 4-beat burst, then contention and a fresh m1 request.
    run_txn(1, 0, 3, 3, 2'b00, 0, 0, 1);
    run_txn(1, 1, 1, 1, 2'b00, 0, 0, -1);
    run_txn(0, 1, 1, 1, 2'b01, 0, 1, -1);

    // Random transactions checked against the model pointer.
    for (int i = 0; i < 40; i++) begin
      r0 = $urandom_range(0, 1);
      r1 = (r0 == 0) ? 1 : $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      wl = ($urandom_range(0, 1) == 0) ? len : $urandom_range(0, 15);
      g = (r0 != 0 && r1 != 0) ? ptr : r1;
      run_txn(r0[0], r1[0], len, wl, 2'($urandom), 1'($urandom_range(0, 1)), g, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
